dma_priority_arbiter: RTL and testbench
=======================================

DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET_N  input  1  reset, asynchronous, active-low.
REQ-003 DREQ  input  4  peripheral DMA requests, ch0..ch3; polarity per commandReg[6].
REQ-004 HLDA  input  1  hold acknowledge from CPU, active-high.
REQ-005 EOP_N  input  1  external/internal end-of-process, active-low.
REQ-006 TC  input  4  per-channel terminal-count pulse from the address/count block.
REQ-007 cycleDone  input  1  one-CLK pulse from the timing control at the end of each transfer (S4).
REQ-008 commandReg  input  8  bit2 controller disable, bit4 rotating priority, bit6 DREQ active-low, bit7 DACK active-high.
REQ-009 modeReg  input  4x8  per-channel mode; bits[7:6]: 00 demand, 01 single, 10 block, 11 cascade.
REQ-010 maskReg  input  4  per-channel hardware-request mask, 1 = masked.
REQ-011 requestReg  input  4  software requests, unaffected by mask and DREQ polarity.
REQ-012 HRQ  output  1  hold request to CPU, registered.
REQ-013 VALID_DREQ  output  4  one-hot granted channel, to timing control.
REQ-014 DACK  output  4  per-channel acknowledge, polarity per commandReg[7].
REQ-015 activeCh  output  2  binary index of locked channel.
REQ-016 reqStatus  output  4  registered effective request vector, feeds statusReg[7:4].

Function
REQ-017 DREQ SHALL be registered once; effective req[i] = ((DREQ_r[i] ^ commandReg[6]) & ~maskReg[i]) | requestReg[i].
REQ-018 States SHALL be IDLE, REQ, SERVE; one-hot encoded.
REQ-019 IDLE: if any req and commandReg[2]==0, SHALL lock highest-priority requester into activeCh, set HRQ=1, go REQ on the same edge.
REQ-020 Latency: DREQ asserted before edge k -> DREQ_r at k -> HRQ=1 after edge k+1.
REQ-021 REQ: HLDA==1 -> SERVE, VALID_DREQ/DACK asserted for locked channel from next cycle; locked req drops before HLDA -> IDLE, HRQ=0; a higher-priority arrival SHALL NOT preempt the lock.
REQ-022 SERVE on cycleDone: single -> IDLE; block -> stay unless TC[activeCh] or EOP_N==0; demand -> IDLE if TC[activeCh], EOP_N==0 or req[activeCh]==0.
REQ-023 Cascade channel SHALL remain in SERVE, ignoring cycleDone, until req[activeCh]==0.
REQ-024 SERVE: EOP_N==0 or HLDA==0 at any edge SHALL force IDLE, clearing HRQ, VALID_DREQ and DACK the next cycle.
REQ-025 Leaving SERVE SHALL spend at least one cycle in IDLE with HRQ=0 before re-arbitration.
REQ-026 Fixed priority: ch0 highest, ch3 lowest.
REQ-027 Rotating priority (commandReg[4]=1): on exit from SERVE the served channel becomes lowest, order wraps modulo 4 (served 3 -> ch0 highest).
REQ-028 commandReg[2]=1 SHALL block new arbitration only; a grant in REQ/SERVE completes normally.
REQ-029 Inactive DACK lines SHALL sit at the inactive level (1 when commandReg[7]=0, 0 when 1).
REQ-030 reqStatus SHALL update every cycle regardless of state.

Reset
REQ-031 RESET_N low SHALL immediately force IDLE, HRQ=0, VALID_DREQ=0, DACK=4'b1111, activeCh=0, reqStatus=0, DREQ_r=0, rotation pointer=ch0 highest, including mid-transfer.

Configuration
REQ-032 DMA_ROTATE_PRIORITY_EN defined: REQ-027 implemented; undefined: fixed priority only, commandReg[4] ignored, no rotation pointer.

Verification
REQ-033 DREQ=4'b0110, fixed, single mode, HLDA after 2 cycles -> activeCh=1, VALID_DREQ=4'b0010, DACK=4'b1101; after cycleDone HRQ=0 then ch2 granted.
REQ-034 Rotating on, ch0..ch3 all requesting, single mode, 4 transfers -> grant order 0,1,2,3, fifth grant ch0.
REQ-035 Block mode ch3, TC[3] on third cycleDone -> three transfers, then IDLE, HRQ=0.
REQ-036 Demand mode ch2, DREQ[2] drops before second cycleDone -> IDLE after second transfer.
REQ-037 maskReg=4'b0001, DREQ=4'b0001, requestReg=0 -> HRQ stays 0; requestReg=4'b0001 -> HRQ=1 two edges later.
REQ-038 RESET_N low during SERVE -> HRQ=0, DACK=4'b1111 without waiting for CLK.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: request conditioning, IDLE/REQ/SERVE hold handshake and channel grant.
// Define DMA_ROTATE_PRIORITY_EN to enable rotating priority (commandReg[4]); otherwise fixed ch0-highest.
module dma_priority_arbiter (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [3:0]      DREQ,
  input  logic            HLDA,
  input  logic            EOP_N,
  input  logic [3:0]      TC,
  input  logic            cycleDone,
  input  logic [7:0]      commandReg,
  input  logic [3:0][7:0] modeReg,
  input  logic [3:0]      maskReg,
  input  logic [3:0]      requestReg,
  output logic            HRQ,
  output logic [3:0]      VALID_DREQ,
  output logic [3:0]      DACK,
  output logic [1:0]      activeCh,
  output logic [3:0]      reqStatus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    REQ   = 3'b010,
    SERVE = 3'b100
  } state_t;

  state_t     state;
  logic [3:0] dreq_r;
  logic [3:0] sw_req_r;
  logic [3:0] req;
  logic [1:0] top;
  logic [1:0] winner;
  logic [1:0] mode;
  logic       serve_done;
  logic [3:0] valid_next;
  logic       unused_cfg;

`ifdef DMA_ROTATE_PRIORITY_EN
  logic [1:0] rot_ptr;
  assign top        = commandReg[4] ? rot_ptr : 2'd0;
  assign unused_cfg = ^{commandReg[5], commandReg[3], commandReg[1:0],
                        modeReg[0][5:0], modeReg[1][5:0], modeReg[2][5:0], modeReg[3][5:0]};
`else
  assign top        = 2'd0;
  assign unused_cfg = ^{commandReg[5], commandReg[4], commandReg[3], commandReg[1:0],
                        modeReg[0][5:0], modeReg[1][5:0], modeReg[2][5:0], modeReg[3][5:0]};
`endif

  // Software requests are sampled alongside DREQ so both paths share the same latency.
  assign req  = ((dreq_r ^ {4{commandReg[6]}}) & ~maskReg) | sw_req_r;
  assign mode = modeReg[activeCh][7:6];

  always_comb begin
    logic [1:0] idx;
    winner = top;
    idx    = top;
    for (int k = 3; k >= 0; k--) begin
      idx = top + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_comb begin
    serve_done = 1'b0;
    if (!EOP_N || !HLDA) begin
      serve_done = 1'b1;
    end else begin
      case (mode)
        2'b11:   serve_done = !req[activeCh];
        2'b01:   serve_done = cycleDone;
        2'b10:   serve_done = cycleDone && TC[activeCh];
        default: serve_done = cycleDone && (TC[activeCh] || !req[activeCh]);
      endcase
    end
  end

  always_comb begin
    valid_next = 4'b0000;
    case (state)
      REQ:     if (HLDA) valid_next = 4'b0001 << activeCh;
      SERVE:   if (!serve_done) valid_next = 4'b0001 << activeCh;
      default: valid_next = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      HRQ        <= 1'b0;
      VALID_DREQ <= 4'b0000;
      DACK       <= 4'b1111;
      activeCh   <= 2'd0;
      reqStatus  <= 4'b0000;
      dreq_r     <= 4'b0000;
      sw_req_r   <= 4'b0000;
`ifdef DMA_ROTATE_PRIORITY_EN
      rot_ptr    <= 2'd0;
`endif
    end else begin
      dreq_r     <= DREQ;
      sw_req_r   <= requestReg;
      reqStatus  <= req;
      VALID_DREQ <= valid_next;
      DACK       <= valid_next ^ {4{~commandReg[7]}};
      case (state)
        IDLE: begin
          if (|req && !commandReg[2]) begin
            activeCh <= winner;
            HRQ      <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          // The lock holds until HLDA or a drop of the locked request; no preemption.
          if (HLDA) begin
            state <= SERVE;
          end else if (!req[activeCh]) begin
            HRQ   <= 1'b0;
            state <= IDLE;
          end
        end
        SERVE: begin
          if (serve_done) begin
            HRQ   <= 1'b0;
            state <= IDLE;
`ifdef DMA_ROTATE_PRIORITY_EN
            if (commandReg[4]) rot_ptr <= activeCh + 2'd1;
`endif
          end
        end
        default: begin
          HRQ   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_dma_priority_arbiter;

`ifdef DMA_ROTATE_PRIORITY_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic            CLK;
  logic            RESET_N;
  logic [3:0]      DREQ;
  logic            HLDA;
  logic            EOP_N;
  logic [3:0]      TC;
  logic            cycleDone;
  logic [7:0]      commandReg;
  logic [3:0][7:0] modeReg;
  logic [3:0]      maskReg;
  logic [3:0]      requestReg;
  logic            HRQ;
  logic [3:0]      VALID_DREQ;
  logic [3:0]      DACK;
  logic [1:0]      activeCh;
  logic [3:0]      reqStatus;

  int total = 0;
  int bad   = 0;

  dma_priority_arbiter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N(EOP_N),
    .TC(TC), .cycleDone(cycleDone), .commandReg(commandReg), .modeReg(modeReg),
    .maskReg(maskReg), .requestReg(requestReg), .HRQ(HRQ), .VALID_DREQ(VALID_DREQ),
    .DACK(DACK), .activeCh(activeCh), .reqStatus(reqStatus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: phase 0 = idle, 1 = waiting for HLDA, 2 = transferring.
  bit [3:0] m_dreq_r, m_sw_r, m_status, m_valid, m_dack;
  bit       m_hrq;
  int       m_phase, m_ch, m_top;

  task automatic model_reset();
    m_dreq_r = 0; m_sw_r = 0; m_status = 0; m_valid = 0; m_dack = 4'b1111;
    m_hrq = 0; m_phase = 0; m_ch = 0; m_top = 0;
  endtask

  task automatic model_step();
    bit [3:0] r;
    bit [3:0] one;
    int       top;
    int       mode;
    int       best;
    bit       leave;
    one  = 4'b0001;
    r    = ((m_dreq_r ^ {4{commandReg[6]}}) & ~maskReg) | m_sw_r;
    top  = (ROT_EN && commandReg[4]) ? m_top : 0;
    best = -1;
    case (m_phase)
      0: if (r != 0 && !commandReg[2]) begin
        for (int d = 0; d < 4; d++)
          if (best < 0 && r[(top + d) % 4]) best = (top + d) % 4;
        m_ch = best; m_phase = 1; m_hrq = 1;
      end
      1: if (HLDA) m_phase = 2;
         else if (!r[m_ch]) begin m_phase = 0; m_hrq = 0; end
      default: begin
        mode  = int'(modeReg[m_ch][7:6]);
        leave = !EOP_N || !HLDA;
        if (!leave) begin
          if (mode == 3) leave = !r[m_ch];
          else if (cycleDone) begin
            if (mode == 1) leave = 1;
            else if (mode == 2) leave = TC[m_ch];
            else leave = TC[m_ch] || !r[m_ch];
          end
        end
        if (leave) begin
          m_phase = 0; m_hrq = 0;
          if (ROT_EN && commandReg[4]) m_top = (m_ch + 1) % 4;
        end
      end
    endcase
    m_valid  = (m_phase == 2) ? (one << m_ch) : 4'b0000;
    m_dack   = commandReg[7] ? m_valid : ~m_valid;
    m_status = r;
    m_dreq_r = DREQ;
    m_sw_r   = requestReg;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    checkOutput("HRQ", 32'(HRQ), 32'(m_hrq));
    checkOutput("VALID_DREQ", 32'(VALID_DREQ), 32'(m_valid));
    checkOutput("DACK", 32'(DACK), 32'(m_dack));
    checkOutput("activeCh", 32'(activeCh), 32'(m_ch));
    checkOutput("reqStatus", 32'(reqStatus), 32'(m_status));
  endtask

  task automatic applyStimulus();
    @(posedge CLK);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    bit       cmd6;
    bit [3:0] dreq;
    bit [3:0] mask;
    bit [3:0] sw;
    bit [3:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit [7:0] c;
    RESET_N = 1'b0; DREQ = 0; HLDA = 0; EOP_N = 1; TC = 0; cycleDone = 0;
    commandReg = 8'h00; maskReg = 0; requestReg = 0;
    for (int i = 0; i < 4; i++) modeReg[i] = 8'h40;
    model_reset();

    tbl[0] = '{0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1] = '{0, 4'b0101, 4'b0000, 4'b0000, 4'b0101};
    tbl[2] = '{0, 4'b1111, 4'b0110, 4'b0000, 4'b1001};
    tbl[3] = '{1, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[4] = '{1, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    tbl[5] = '{1, 4'b0011, 4'b1000, 4'b0000, 4'b0100};
    tbl[6] = '{0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    tbl[7] = '{0, 4'b0000, 4'b1111, 4'b1010, 4'b1010};
    tbl[8] = '{1, 4'b1111, 4'b1111, 4'b0001, 4'b0001};

    #12;
    checkOutput("reset_HRQ", 32'(HRQ), 0);
    checkOutput("reset_DACK", 32'(DACK), 32'hF);
    checkOutput("reset_VALID", 32'(VALID_DREQ), 0);
    checkOutput("reset_activeCh", 32'(activeCh), 0);
    checkOutput("reset_reqStatus", 32'(reqStatus), 0);
    RESET_N = 1'b1;

    // Request conditioning with arbitration disabled.
    for (int i = 0; i < 9; i++) begin
      commandReg = {1'b0, tbl[i].cmd6, 6'b000100};
      DREQ = tbl[i].dreq; maskReg = tbl[i].mask; requestReg = tbl[i].sw;
      applyStimulus(); applyStimulus();
      checkOutput("tbl_reqStatus", 32'(reqStatus), 32'(tbl[i].exp));
      checkOutput("tbl_HRQ_blocked", 32'(HRQ), 0);
    end
    commandReg = 8'h00; DREQ = 0; maskReg = 0; requestReg = 0;
    applyStimulus(); applyStimulus();

    // Masked hardware request never raises HRQ; software request does, two edges later.
    maskReg = 4'b0001; DREQ = 4'b0001;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("req037_masked_HRQ", 32'(HRQ), 0);
    requestReg = 4'b0001;
    applyStimulus();
    checkOutput("req037_edge1_HRQ", 32'(HRQ), 0);
    applyStimulus();
    checkOutput("req037_edge2_HRQ", 32'(HRQ), 1);
    checkOutput("req037_activeCh", 32'(activeCh), 0);
    requestReg = 0; DREQ = 0; maskReg = 0;
    applyStimulus(); applyStimulus(); applyStimulus();
    checkOutput("req037_drop_HRQ", 32'(HRQ), 0);

    // Two requesters, fixed priority, single mode.
    DREQ = 4'b0110;
    applyStimulus(); applyStimulus();
    checkOutput("req033_HRQ", 32'(HRQ), 1);
    checkOutput("req033_activeCh", 32'(activeCh), 1);
    applyStimulus(); applyStimulus();
    HLDA = 1;
    applyStimulus();
    checkOutput("req033_VALID", 32'(VALID_DREQ), 32'h2);
    checkOutput("req033_DACK", 32'(DACK), 32'hD);
    DREQ = 4'b0100; cycleDone = 1;
    applyStimulus();
    checkOutput("req033_done_HRQ", 32'(HRQ), 0);
    checkOutput("req033_done_DACK", 32'(DACK), 32'hF);
    cycleDone = 0; HLDA = 0;
    applyStimulus();
    checkOutput("req033_next_activeCh", 32'(activeCh), 2);
    checkOutput("req033_next_HRQ", 32'(HRQ), 1);
    HLDA = 1;
    applyStimulus();
    checkOutput("req033_next_VALID", 32'(VALID_DREQ), 32'h4);
    DREQ = 0; cycleDone = 1;
    applyStimulus();
    cycleDone = 0; HLDA = 0;
    applyStimulus(); applyStimulus();

    // Block mode on ch3 ends on the terminal count of the third transfer.
    modeReg[3] = 8'h80; DREQ = 4'b1000;
    applyStimulus(); applyStimulus();
    checkOutput("req035_activeCh", 32'(activeCh), 3);
    HLDA = 1;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      cycleDone = 1;
      TC = (i == 2) ? 4'b1000 : 4'b0000;
      if (i == 2) DREQ = 0;
      applyStimulus();
      cycleDone = 0; TC = 0;
      if (i < 2) checkOutput("req035_stay_VALID", 32'(VALID_DREQ), 32'h8);
      else begin
        checkOutput("req035_end_HRQ", 32'(HRQ), 0);
        checkOutput("req035_end_VALID", 32'(VALID_DREQ), 0);
      end
      applyStimulus();
    end
    HLDA = 0; modeReg[3] = 8'h40;
    applyStimulus();

    // Demand mode on ch2 ends when the request is gone at the second transfer.
    modeReg[2] = 8'h00; DREQ = 4'b0100;
    applyStimulus(); applyStimulus();
    HLDA = 1;
    applyStimulus();
    cycleDone = 1;
    applyStimulus();
    cycleDone = 0;
    checkOutput("req036_first_VALID", 32'(VALID_DREQ), 32'h4);
    DREQ = 0;
    applyStimulus();
    checkOutput("req036_wait_VALID", 32'(VALID_DREQ), 32'h4);
    cycleDone = 1;
    applyStimulus();
    checkOutput("req036_end_HRQ", 32'(HRQ), 0);
    cycleDone = 0; HLDA = 0; modeReg[2] = 8'h40;
    applyStimulus();

    // All four requesting with the rotate bit set.
    commandReg = 8'h10; DREQ = 4'b1111;
    applyStimulus(); applyStimulus();
    for (int g = 0; g < 5; g++) begin
      checkOutput("req034_grant", 32'(activeCh), ROT_EN ? (g % 4) : 0);
      HLDA = 1;
      applyStimulus();
      cycleDone = 1;
      applyStimulus();
      cycleDone = 0; HLDA = 0;
      applyStimulus();
    end
    DREQ = 0;
    applyStimulus(); applyStimulus(); applyStimulus();
    commandReg = 8'h00;

    // Asynchronous reset in the middle of a transfer.
    DREQ = 4'b0001;
    applyStimulus(); applyStimulus();
    HLDA = 1;
    applyStimulus();
    checkOutput("req038_pre_VALID", 32'(VALID_DREQ), 32'h1);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("req038_HRQ", 32'(HRQ), 0);
    checkOutput("req038_DACK", 32'(DACK), 32'hF);
    checkOutput("req038_VALID", 32'(VALID_DREQ), 0);
    model_reset();
    DREQ = 0; HLDA = 0;
    #3 RESET_N = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) begin
        c = 8'($urandom) & 8'hD0;
        if ($urandom_range(0, 9) == 0) c[2] = 1'b1;
        commandReg = c;
        for (int ch = 0; ch < 4; ch++) modeReg[ch] = {2'($urandom_range(0, 3)), 6'b0};
        maskReg = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      end
      if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
      requestReg = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
      HLDA      = ($urandom_range(0, 9) != 0) ? m_hrq : ~m_hrq;
      EOP_N     = ($urandom_range(0, 19) != 0);
      TC        = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      cycleDone = ($urandom_range(0, 2) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
